// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR accumulate/saturate output stage:
// default widths and a generic signed-saturate helper.
package fir_filter_pkg;

  localparam int DEF_INPUT_WIDTH   = 32;
  localparam int DEF_OUTPUT_WIDTH  = 32;
  localparam int DEF_ACC_WIDTH     = 40;
  localparam int DEF_TAP_CNT_WIDTH = 8;

  // Working width of the saturate helper; callers sign-extend into it.
  localparam int SAT_CALC_WIDTH = 64;

  // Clamp a signed value to the signed range of out_width bits.
  // clamped reports whether the value had to be limited.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_clamp(
    input  logic signed [SAT_CALC_WIDTH-1:0] value,
    input  int                               out_width,
    output logic                             clamped
  );
    logic signed [SAT_CALC_WIDTH-1:0] max_v;
    logic signed [SAT_CALC_WIDTH-1:0] min_v;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    clamped = 1'b0;
    if (value > max_v) begin
      clamped = 1'b1;
      return max_v;
    end
    if (value < min_v) begin
      clamped = 1'b1;
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/fir_filter_as_sat.sv
// Combinational conversion of the wide accumulator sum to the output width.
// With FIR_FILTER_AS_SATURATE_EN defined the sum is clamped to the signed
// output range and sat flags the clamp; otherwise the low bits are kept and
// sat is tied low.
module fir_filter_as_sat
  import fir_filter_pkg::*;
#(
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]    sum_in,
  output logic signed [OUTPUT_WIDTH-1:0] result,
  output logic                           sat
);

`ifdef FIR_FILTER_AS_SATURATE_EN
  logic signed [SAT_CALC_WIDTH-1:0] wide;
  logic signed [SAT_CALC_WIDTH-1:0] clamped_wide;
  logic                             unused_hi;

  assign wide = SAT_CALC_WIDTH'(sum_in);

  // Clamp the sign-extended sum into the signed output range.
  always_comb begin
    sat          = 1'b0;
    clamped_wide = sat_clamp(wide, OUTPUT_WIDTH, sat);
  end

  assign result    = clamped_wide[OUTPUT_WIDTH-1:0];
  assign unused_hi = ^clamped_wide[SAT_CALC_WIDTH-1:OUTPUT_WIDTH];
`else
  logic unused_hi;

  assign result    = sum_in[OUTPUT_WIDTH-1:0];
  assign sat       = 1'b0;
  assign unused_hi = ^sum_in;
`endif

endmodule

// File: rtl/fir_filter_as_stage.sv
// FIR accumulate stage: sums signed tap products into a wide accumulator and
// presents one converted result per output sample on a valid/ready port.
// Optional saturation of the result: define FIR_FILTER_AS_SATURATE_EN.
//
// Handshake: result_valid rises when a result loads and stays high with
// result_out/taps_out/sat_out stable until a cycle with result_ready high;
// the result is taken on that edge. A new final product arriving while an
// untaken result is held raises stall_out so the upstream register freezes
// and nothing is lost. freeze stalls accumulation but never the handshake.
module fir_filter_as_stage
  import fir_filter_pkg::*;
#(
  parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int TAP_CNT_WIDTH = DEF_TAP_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic signed [INPUT_WIDTH-1:0]  mult_corrected_in,
  input  logic                           overwrite_in,
  input  logic                           output_valid_in,
  output logic                           stall_out,
  output logic signed [OUTPUT_WIDTH-1:0] result_out,
  output logic [TAP_CNT_WIDTH-1:0]       taps_out,
  output logic                           sat_out,
  output logic                           result_valid,
  input  logic                           result_ready
);

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    sum_next;
  logic [TAP_CNT_WIDTH-1:0]       tap_cnt;
  logic [TAP_CNT_WIDTH-1:0]       tap_next;
  logic                           acc_en;
  logic                           load;
  logic signed [OUTPUT_WIDTH-1:0] conv_result;
  logic                           conv_sat;

  assign stall_out = result_valid & ~result_ready & output_valid_in;
  assign acc_en    = ~freeze & ~flush & ~stall_out;
  assign load      = acc_en & output_valid_in;

  assign prod_ext = ACC_WIDTH'(mult_corrected_in);
  assign sum_next = (overwrite_in ? '0 : acc) + prod_ext;

  // Tap count restarts at one on overwrite and otherwise counts up,
  // sticking at all-ones rather than wrapping.
  always_comb begin
    tap_next = tap_cnt;
    if (overwrite_in) begin
      tap_next = TAP_CNT_WIDTH'(1);
    end else if (~&tap_cnt) begin
      tap_next = tap_cnt + TAP_CNT_WIDTH'(1);
    end
  end

  fir_filter_as_sat #(
    .ACC_WIDTH    (ACC_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_sat (
    .sum_in (sum_next),
    .result (conv_result),
    .sat    (conv_sat)
  );

  // Accumulator and tap counter: cleared by reset or flush, advance on acc_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (flush) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (acc_en) begin
      acc     <= sum_next;
      tap_cnt <= tap_next;
    end
  end

  // Output register: loads on the final product, held until taken; a load in
  // the handshake cycle keeps valid high for bubble-free back-to-back results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_out   <= '0;
      taps_out     <= '0;
      sat_out      <= 1'b0;
      result_valid <= 1'b0;
    end else if (flush) begin
      result_valid <= 1'b0;
    end else if (load) begin
      result_out   <= conv_result;
      taps_out     <= tap_next;
      sat_out      <= conv_sat;
      result_valid <= 1'b1;
    end else if (result_valid & result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_filter_as_stage.sv
// Self-checking bench for fir_filter_as_stage (OUTPUT_WIDTH=8, ACC_WIDTH=24,
// TAP_CNT_WIDTH=4). Honours FIR_FILTER_AS_SATURATE_EN in its reference model.
module tb_fir_filter_as_stage;

  localparam int IW = 16;
  localparam int OW = 8;
  localparam int AW = 24;
  localparam int TW = 4;
  localparam int EW = 1 + TW + OW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  hold = 1'b1;
  logic                  rand_frz = 1'b0;
  logic                  freeze;
  logic                  flush = 1'b0;
  logic signed [IW-1:0]  mult_corrected_in = '0;
  logic                  overwrite_in = 1'b0;
  logic                  output_valid_in = 1'b0;
  logic                  stall_out;
  logic signed [OW-1:0]  result_out;
  logic [TW-1:0]         taps_out;
  logic                  sat_out;
  logic                  result_valid;
  logic                  result_ready = 1'b1;

  assign freeze = hold | rand_frz;

  fir_filter_as_stage #(
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .ACC_WIDTH     (AW),
    .TAP_CNT_WIDTH (TW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .flush             (flush),
    .mult_corrected_in (mult_corrected_in),
    .overwrite_in      (overwrite_in),
    .output_valid_in   (output_valid_in),
    .stall_out         (stall_out),
    .result_out        (result_out),
    .taps_out          (taps_out),
    .sat_out           (sat_out),
    .result_valid      (result_valid),
    .result_ready      (result_ready)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int accepted_cnt = 0;
  bit rand_mode = 1'b0;

  logic [EW-1:0] exp_q[$];
  longint        m_sum  = 0;
  int            m_taps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output word {sat, taps, result} for a running sum and tap count.
  function automatic logic [EW-1:0] expect_of(input longint s, input int t);
    longint      w;
    logic [OW-1:0] r;
    logic        sat;
    w = s & 64'hFF_FFFF;                 // accumulator wraps at AW bits
    if (w >= (64'sd1 <<< (AW - 1))) w = w - (64'sd1 <<< AW);
`ifdef FIR_FILTER_AS_SATURATE_EN
    if (w > 127) begin
      r = 8'h7F; sat = 1'b1;
    end else if (w < -128) begin
      r = 8'h80; sat = 1'b1;
    end else begin
      r = w[OW-1:0]; sat = 1'b0;
    end
`else
    r   = w[OW-1:0];
    sat = 1'b0;
`endif
    return {sat, TW'(t), r};
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // A result is outstanding while the expected queue is non-empty. A new
  // final product cannot enter while one is outstanding and not being taken.
  always @(negedge clk) begin
    logic          exp_stall;
    logic [EW-1:0] head;
    if (!rst) begin
      exp_stall = (exp_q.size() != 0) && !result_ready && output_valid_in;
      check("result_valid", 32'(result_valid), 32'(exp_q.size() != 0));
      check("stall_out", 32'(stall_out), 32'(exp_stall));
      if (result_valid && exp_q.size() != 0) begin
        head = exp_q[0];
        check("result_out", 32'(result_out[OW-1:0]), 32'(head[OW-1:0]));
        check("taps_out", 32'(taps_out), 32'(head[OW+TW-1:OW]));
        check("sat_out", 32'(sat_out), 32'(head[EW-1]));
        if (result_ready) void'(exp_q.pop_front());
      end
      if (flush) begin
        m_sum  = 0;
        m_taps = 0;
        exp_q.delete();
      end else if (!freeze && !exp_stall) begin
        if (overwrite_in) begin
          m_sum  = longint'(mult_corrected_in);
          m_taps = 1;
        end else begin
          m_sum = m_sum + longint'(mult_corrected_in);
          if (m_taps < (1 << TW) - 1) m_taps++;
        end
        if (output_valid_in) exp_q.push_back(expect_of(m_sum, m_taps));
        accepted_cnt++;
      end
    end
  end

  // Random backpressure and freeze during the randomized phase.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      result_ready = ($urandom_range(0, 3) != 0);
      rand_frz     = ($urandom_range(0, 5) == 0);
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic signed [IW-1:0] p, input bit ow, input bit ov);
    int start;
    int n;
    mult_corrected_in = p;
    overwrite_in      = ow;
    output_valid_in   = ov;
    hold              = 1'b0;
    start = accepted_cnt;
    n = 0;
    while (accepted_cnt == start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (accepted_cnt == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: product %0d not taken after %0d cycles", p, n);
    end
    hold            = 1'b1;
    overwrite_in    = 1'b0;
    output_valid_in = 1'b0;
  endtask

  // Frozen cycles with junk on the product inputs; none of it may be summed.
  task automatic idle(input int k);
    hold = 1'b1;
    for (int i = 0; i < k; i++) begin
      mult_corrected_in = IW'($urandom);
      overwrite_in      = 1'($urandom);
      output_valid_in   = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    hold            = 1'b1;
    output_valid_in = 1'b0;
    flush           = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_result"}, 32'(result_out[OW-1:0]), 32'd0);
    check({tag, "_taps"}, 32'(taps_out), 32'd0);
    check({tag, "_sat"}, 32'(sat_out), 32'd0);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 3 + -1 + 5 = 7 over three taps, single-cycle valid pulse
    result_ready = 1'b1;
    send(3, 1, 0); send(-1, 0, 0); send(5, 0, 1);
    idle(3);

    // back-to-back one-tap samples
    send(10, 1, 1); send(20, 1, 1);
    idle(3);

    // held result, next final product stalls until ready returns
    result_ready = 1'b0;
    send(5, 1, 1);
    send(2, 1, 0);
    fork
      send(9, 0, 1);
      begin
        repeat (4) @(posedge clk);
        #1 result_ready = 1'b1;
      end
    join
    idle(3);

    // handshake completes while frozen
    result_ready = 1'b0;
    send(7, 1, 1);
    idle(2);
    result_ready = 1'b1;
    idle(3);

    // 100 + 100 = 200 does not fit in 8 signed bits
    send(100, 1, 0); send(100, 0, 1);
    idle(2);
    send(-100, 1, 0); send(-100, 0, 1);
    idle(2);

    // flush after two taps, then a fresh sample without overwrite
    send(1, 1, 0); send(1, 0, 0);
    do_flush();
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 1);
    idle(2);

    // freeze mid-sample must not disturb the sum
    send(5, 1, 0); idle(3); send(6, 0, 1);
    idle(2);

    // tap counter sticks at all-ones
    send(1, 1, 0);
    for (int i = 0; i < 18; i++) send(1, 0, 0);
    send(1, 0, 1);
    idle(2);

    // asynchronous reset mid-sample with a held result
    result_ready = 1'b0;
    send(6, 1, 1); send(3, 1, 0); send(4, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    m_sum  = 0;
    m_taps = 0;
    exp_q.delete();
    rst = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    send(4, 0, 0); send(4, 0, 1);
    idle(3);

    // randomized samples with random backpressure and freeze
    rand_mode = 1'b1;
    for (int s = 0; s < 60; s++) begin
      int n_taps;
      n_taps = $urandom_range(1, 5);
      for (int t = 0; t < n_taps; t++) begin
        logic signed [IW-1:0] p;
        if ($urandom_range(0, 9) == 0) p = IW'($urandom);
        else p = IW'(int'($urandom_range(0, 600)) - 300);
        send(p, (t == 0) && ($urandom_range(0, 3) != 0), t == n_taps - 1);
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    rand_frz     = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fir_filter_as_stage.md
FIR_FILTER_AS_STAGE -- requirements
Module: fir_filter_as_stage

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, width of the corrected product from the multiply/accumulate-stage register.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32, width of the filter result.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, internal signed accumulator width (>= INPUT_WIDTH+1, >= OUTPUT_WIDTH).
REQ-004 SHALL have parameter TAP_CNT_WIDTH, default 8, width of the tap counter.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 freeze  input  1  global pipeline stall; no state update while high.
REQ-008 flush  input  1  synchronous pipeline flush.
REQ-009 mult_corrected_in  input  INPUT_WIDTH  signed product for the current tap.
REQ-010 overwrite_in  input  1  product starts a new sum; prior accumulator content discarded.
REQ-011 output_valid_in  input  1  product is the last tap of the current output sample.
REQ-012 stall_out  input-side output  1  backpressure to the upstream register's freeze.
REQ-013 result_out  output  OUTPUT_WIDTH  signed filter result.
REQ-014 taps_out  output  TAP_CNT_WIDTH  products summed into result_out.
REQ-015 sat_out  output  1  result_out was clamped (macro-dependent).
REQ-016 result_valid  output  1  result_out/taps_out/sat_out valid.
REQ-017 result_ready  input  1  downstream accepts the result.

Function
REQ-018 stall_out SHALL equal result_valid & ~result_ready & output_valid_in (combinational).
REQ-019 acc_en SHALL equal ~freeze & ~flush & ~stall_out; accumulator and tap counter SHALL update only when acc_en is high.
REQ-020 On acc_en, sum_next SHALL be (overwrite_in ? 0 : acc) + sign-extended mult_corrected_in, wrapping modulo 2^ACC_WIDTH; acc SHALL load sum_next.
REQ-021 On acc_en, tap count SHALL load 1 if overwrite_in, else increment, saturating at all-ones.
REQ-022 On acc_en & output_valid_in, result_out SHALL load the OUTPUT_WIDTH conversion of sum_next, taps_out the new tap count, result_valid SHALL be set; latency is one cycle from the final product.
REQ-023 result_valid SHALL clear on result_valid & result_ready unless a new result loads in the same cycle, in which case it SHALL stay high (bubble-free back-to-back).
REQ-024 While result_valid & ~result_ready, result_out/taps_out/sat_out SHALL hold stable.
REQ-025 flush SHALL clear acc, tap count, and result_valid on the next edge; it takes priority over freeze and acc_en.
REQ-026 freeze SHALL NOT block the result handshake; result_valid clears on result_ready even while frozen.

Reset
REQ-027 rst high SHALL immediately clear acc, tap count, result_out, taps_out, sat_out, result_valid to 0; stall_out then evaluates to 0.
REQ-028 rst asserted mid-sample SHALL discard the partial sum; the next sum starts with the next product regardless of overwrite_in.

Configuration
REQ-029 Macro FIR_FILTER_AS_SATURATE_EN defined: conversion SHALL clamp sum_next to the signed OUTPUT_WIDTH range and sat_out SHALL be 1 when clamped.
REQ-030 Macro undefined: conversion SHALL truncate to the low OUTPUT_WIDTH bits and sat_out SHALL be constant 0.

Structure
REQ-031 Default widths and a signed-saturate function SHALL live in shared package fir_filter_pkg.
REQ-032 The conversion SHALL be a sub-module fir_filter_as_sat (combinational, ACC_WIDTH in, OUTPUT_WIDTH + sat flag out).

Verification
REQ-033 Products 3, -1, 5 (overwrite on first, output_valid on last), ready=1 -> result_out=7, taps_out=3, one-cycle valid pulse.
REQ-034 Two back-to-back 1-tap samples 10 then 20 with ready=1 -> result_valid high two consecutive cycles, outputs 10 then 20.
REQ-035 result held, ready=0, next output_valid arrives -> stall_out=1, acc unchanged; ready=1 -> new result loads same cycle, no loss.
REQ-036 Saturate build, OUTPUT_WIDTH=8, sum 200 -> result_out=127, sat_out=1; non-saturate build -> result_out=-56, sat_out=0.
REQ-037 flush after two of three taps, then fresh 3-tap sample 1,1,1 -> result_out=3; freeze mid-sample -> sum unchanged vs unfrozen run.
REQ-038 rst pulse mid-sample asynchronous to clk -> all outputs 0 before next edge; following sample correct.
